hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Hazard/scheduling controller for the 5-stage pipeline: decides each cycle whether the ID-stage instruction
//  issues into ID/EX, is held (load-use stall) or is killed (EX redirect). Keeps a 2-deep scoreboard of in-flight
//  writers (EX, MEM) and generates the forwarding selects registered into ID/EX. Also counts stall cycles.
// PARAMETERS
//  AW     5   register address width
//  CNT_W  16  width of stall_count (saturating)
// PORTS
//  clk              in   1     clock
//  rst              in   1     reset, synchronous, active-low
//  id_valid         in   1     ID holds a real instruction
//  id_rs1_addr      in   AW    source 1 address
//  id_rs2_addr      in   AW    source 2 address
//  id_uses_rs1      in   1     instruction reads rs1
//  id_uses_rs2      in   1     instruction reads rs2 (register, not immediate)
//  id_rd_addr       in   AW    destination address
//  id_wb_en         in   1     instruction writes rd
//  id_is_load       in   1     instruction writes rd from memory
//  ex_redirect      in   1     taken branch/jump resolved in EX this cycle
//  stall_if_id      out  1     hold PC and IF/ID
//  flush_if_id      out  1     replace IF/ID contents with a bubble
//  bubble_id_ex     out  1     load a NOP into ID/EX instead of ID contents
//  rs1_fwd_sel      out  2     00 regfile, 01 prev1 (EX result), 10 prev2 (MEM/WB result)
//  rs2_fwd_sel      out  2     same encoding for rs2
//  stall_count      out  CNT_W stall cycles since reset
// BEHAVIOUR
//  - Scoreboard slots EX and MEM, each {valid, rd, wb_en, is_load}; a slot "writes r" iff valid & wb_en & rd==r & r!=0.
//  - Every clock: MEM <= EX; EX <= ID fields with valid=id_valid when issuing, else valid=0 (bubble or kill).
//  - Load-use: EX slot is_load and writes a used source of a valid ID instr -> stall_if_id=1, bubble_id_ex=1,
//    counter +1. Exactly one stall cycle; next cycle the load sits in MEM and fwd_sel=10.
//  - Redirect: ex_redirect=1 -> flush_if_id=1, bubble_id_ex=1, stall_if_id=0, EX slot loaded invalid.
//    Redirect wins over a simultaneous load-use stall; that cycle is not counted.
//  - Forwarding (per source, only when the source is used): EX slot writes it -> 01; else MEM slot -> 10; else 00.
//    Priority to EX (youngest). Address 0 always 00. Unused source always 00.
//  - Forwarding and stall/bubble/flush outputs are combinational from scoreboard + ID inputs (same-cycle).
//  - stall_count saturates at 2^CNT_W-1; holds there, no wrap.
//  - Reset (rst==0 at posedge): both slots invalid, stall_count=0. While rst==0 outputs are forced:
//    stall_if_id=0, flush_if_id=1, bubble_id_ex=1, fwd_sel=00. Reset mid-stall drops the stall in that cycle.
//  - id_valid=0 never stalls; it still flows in as an invalid EX slot.
// STRUCTURE
//  - pipe_pkg: fwd_sel_e enum {FWD_REG=2'b00, FWD_PREV1=2'b01, FWD_PREV2=2'b10}; sb_slot_t struct {valid, rd, wb_en,
//    is_load}; REG_ZERO constant.
//  - Sub-module fwd_select (combinational): one source address + uses flag + two slots -> fwd_sel_e and load_hit;
//    instantiated twice (rs1, rs2). Scoreboard regs, stall logic and counter stay in hazard_ctrl.
// TESTING
//  1. Reset: hold rst=0 for 3 cycles -> flush=1, bubble=1, stall=0, fwd=00, stall_count=0; release -> all deassert.
//  2. add x5 then add x6,x5,x5 back-to-back -> rs1_fwd_sel=rs2_fwd_sel=01, no stall.
//  3. add x5; unrelated; sub x7,x5,x1 -> rs1_fwd_sel=10, rs2=00; x5 written by both EX and MEM -> 01.
//  4. lw x5 then add x6,x5,x0 -> 1 cycle stall+bubble, then rs1_fwd_sel=10; stall_count 0->1.
//  5. lw x5 + dependent in ID with ex_redirect=1 same cycle -> flush=1, bubble=1, stall=0, count unchanged.
//  6. Writers to x0 never forward/stall; CNT_W=2 with 5 load-use stalls -> stall_count saturates at 3.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline types: forwarding select encoding and scoreboard slot layout.
package pipe_pkg;

    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_PREV1 = 2'b01,
        FWD_PREV2 = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              wb_en;
        logic              is_load;
    } sb_slot_t;

    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    // x0 is hardwired, so a write to it never produces a value worth forwarding.
    function automatic logic slot_writes(input sb_slot_t s, input logic [REG_AW-1:0] r);
        return s.valid & s.wb_en & (s.rd == r) & (r != REG_ZERO);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Per-source forwarding select: youngest in-flight writer wins; also flags a load in EX.
module fwd_select
    import pipe_pkg::*;
(
    input  logic [REG_AW-1:0] src_addr,
    input  logic              uses,
    input  sb_slot_t          slot_ex,
    input  sb_slot_t          slot_mem,
    output fwd_sel_e          sel,
    output logic              load_hit
);

    logic ex_hit;
    logic mem_hit;

    always_comb begin
        ex_hit   = uses & slot_writes(slot_ex, src_addr);
        mem_hit  = uses & slot_writes(slot_mem, src_addr);
        load_hit = ex_hit & slot_ex.is_load;
        sel      = FWD_REG;
        if (ex_hit)
            sel = FWD_PREV1;
        else if (mem_hit)
            sel = FWD_PREV2;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage hazard controller: issue/hold/kill decision, EX/MEM writer scoreboard,
// forwarding selects and a saturating stall-cycle counter.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int AW    = REG_AW,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [AW-1:0]    id_rs1_addr,
    input  logic [AW-1:0]    id_rs2_addr,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [AW-1:0]    id_rd_addr,
    input  logic             id_wb_en,
    input  logic             id_is_load,
    input  logic             ex_redirect,
    output logic             stall_if_id,
    output logic             flush_if_id,
    output logic             bubble_id_ex,
    output logic [1:0]       rs1_fwd_sel,
    output logic [1:0]       rs2_fwd_sel,
    output logic [CNT_W-1:0] stall_count
);

    sb_slot_t         ex_q, ex_d;
    sb_slot_t         mem_q, mem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    fwd_sel_e rs1_sel, rs2_sel;
    logic     rs1_load_hit, rs2_load_hit;
    logic     load_use;

    fwd_select u_fwd_rs1 (
        .src_addr (id_rs1_addr),
        .uses     (id_uses_rs1),
        .slot_ex  (ex_q),
        .slot_mem (mem_q),
        .sel      (rs1_sel),
        .load_hit (rs1_load_hit)
    );

    fwd_select u_fwd_rs2 (
        .src_addr (id_rs2_addr),
        .uses     (id_uses_rs2),
        .slot_ex  (ex_q),
        .slot_mem (mem_q),
        .sel      (rs2_sel),
        .load_hit (rs2_load_hit)
    );

    // Redirect outranks load-use: the dependent instruction is being killed anyway.
    always_comb begin
        load_use     = id_valid & (rs1_load_hit | rs2_load_hit);
        stall_if_id  = rst & load_use & ~ex_redirect;
        flush_if_id  = ~rst | ex_redirect;
        bubble_id_ex = ~rst | ex_redirect | load_use;
        rs1_fwd_sel  = rst ? rs1_sel : FWD_REG;
        rs2_fwd_sel  = rst ? rs2_sel : FWD_REG;
        stall_count  = cnt_q;
    end

    always_comb begin
        mem_d         = ex_q;
        ex_d.valid    = id_valid & ~bubble_id_ex;
        ex_d.rd       = id_rd_addr;
        ex_d.wb_en    = id_wb_en;
        ex_d.is_load  = id_is_load;
        cnt_d         = cnt_q;
        if (stall_if_id && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; a second instance with a 2-bit counter shares all inputs.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic       id_uses_rs1, id_uses_rs2, id_wb_en, id_is_load, ex_redirect;

    logic        stall_if_id, flush_if_id, bubble_id_ex;
    logic [1:0]  rs1_fwd_sel, rs2_fwd_sel;
    logic [15:0] stall_count;

    logic        s_stall, s_flush, s_bubble;
    logic [1:0]  s_rs1, s_rs2;
    logic [1:0]  s_count;

    int passes = 0;
    int total  = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.AW(5), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd_addr(id_rd_addr), .id_wb_en(id_wb_en), .id_is_load(id_is_load),
        .ex_redirect(ex_redirect),
        .stall_if_id(stall_if_id), .flush_if_id(flush_if_id), .bubble_id_ex(bubble_id_ex),
        .rs1_fwd_sel(rs1_fwd_sel), .rs2_fwd_sel(rs2_fwd_sel), .stall_count(stall_count)
    );

    hazard_ctrl #(.AW(5), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd_addr(id_rd_addr), .id_wb_en(id_wb_en), .id_is_load(id_is_load),
        .ex_redirect(ex_redirect),
        .stall_if_id(s_stall), .flush_if_id(s_flush), .bubble_id_ex(s_bubble),
        .rs1_fwd_sel(s_rs1), .rs2_fwd_sel(s_rs2), .stall_count(s_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passes++;
        else $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    endtask

    // Control outputs checked as one 7-bit word {stall, flush, bubble, rs1_sel, rs2_sel}.
    task automatic chk_ctl(input string tag, input logic [6:0] exp);
        chk(tag, {25'd0, stall_if_id, flush_if_id, bubble_id_ex, rs1_fwd_sel, rs2_fwd_sel}, {25'd0, exp});
    endtask

    task automatic set_id(input logic v, input logic [4:0] rd, input logic [4:0] r1, input logic u1,
                          input logic [4:0] r2, input logic u2, input logic wb, input logic ld,
                          input logic redir);
        id_valid    = v;
        id_rd_addr  = rd;
        id_rs1_addr = r1;
        id_uses_rs1 = u1;
        id_rs2_addr = r2;
        id_uses_rs2 = u2;
        id_wb_en    = wb;
        id_is_load  = ld;
        ex_redirect = redir;
    endtask

    task automatic nop();
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Advance one clock and settle just after the edge; checks follow at +4.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        nop();
        // Reset: outputs forced even with a dependent-looking instruction in ID.
        for (int i = 0; i < 3; i++) begin
            cyc();
            set_id(1'b1, 5'd6, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
            #3;
            chk_ctl("reset_ctl", 7'b0_1_1_00_00);
            chk("reset_cnt", {16'd0, stall_count}, 32'd0);
        end
        cyc();
        rst = 1'b1;
        nop();
        cyc();
        #3 chk_ctl("release_ctl", 7'b0_0_0_00_00);
        chk("release_cnt", {16'd0, stall_count}, 32'd0);

        // add x5,x1,x2 then add x6,x5,x5 back-to-back
        set_id(1'b1, 5'd5, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        #1 chk_ctl("add_x5_issue", 7'b0_0_0_00_00);
        cyc();
        set_id(1'b1, 5'd6, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        #3 chk_ctl("raw_ex_fwd", 7'b0_0_0_01_01);
        cyc(); nop(); cyc(); nop(); cyc();

        // add x5; unrelated add x8,x1,x2; sub x7,x5,x1
        set_id(1'b1, 5'd5, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc();
        set_id(1'b1, 5'd8, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc();
        set_id(1'b1, 5'd7, 5'd5, 1'b1, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        #3 chk_ctl("raw_mem_fwd", 7'b0_0_0_10_00);
        cyc(); nop(); cyc(); nop(); cyc();

        // x5 written by both EX and MEM: youngest (EX) wins
        set_id(1'b1, 5'd5, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc();
        set_id(1'b1, 5'd5, 5'd3, 1'b1, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc();
        set_id(1'b1, 5'd9, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        #3 chk_ctl("ex_over_mem", 7'b0_0_0_01_00);
        // same sources but marked unused: no forwarding
        set_id(1'b1, 5'd9, 5'd5, 1'b0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0);
        #1 chk_ctl("unused_src", 7'b0_0_0_00_00);
        cyc(); nop(); cyc(); nop(); cyc();

        // lw x5 then add x6,x5,x0: one stall, then forward from MEM
        set_id(1'b1, 5'd5, 5'd2, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc();
        set_id(1'b1, 5'd6, 5'd5, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        #3 chk_ctl("load_use_stall", 7'b1_0_1_01_00);
        chk("cnt_before", {16'd0, stall_count}, 32'd0);
        cyc();
        #3 chk_ctl("load_use_after", 7'b0_0_0_10_00);
        chk("cnt_after", {16'd0, stall_count}, 32'd1);
        cyc(); nop(); cyc(); nop(); cyc();

        // load-use coinciding with a redirect: redirect wins, not counted
        set_id(1'b1, 5'd5, 5'd2, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc();
        set_id(1'b1, 5'd6, 5'd5, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        #3 chk_ctl("redirect_wins", 7'b0_1_1_01_00);
        cyc();
        nop();
        #3 chk("cnt_redirect", {16'd0, stall_count}, 32'd1);
        cyc(); nop(); cyc();

        // writers to x0 never forward or stall
        set_id(1'b1, 5'd0, 5'd2, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc();
        set_id(1'b1, 5'd3, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        #3 chk_ctl("x0_no_hazard", 7'b0_0_0_00_00);
        cyc(); nop(); cyc(); nop(); cyc();

        // invalid ID instruction never stalls
        set_id(1'b1, 5'd5, 5'd2, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc();
        set_id(1'b0, 5'd6, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        #3 chk("invalid_no_stall", {31'd0, stall_if_id}, 32'd0);
        cyc(); nop(); cyc(); nop(); cyc();

        // five more load-use stalls: 16-bit counter reaches 6, 2-bit one holds at 3
        for (int k = 0; k < 5; k++) begin
            set_id(1'b1, 5'd5, 5'd2, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
            cyc();
            set_id(1'b1, 5'd6, 5'd1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
            cyc();
            nop();
            cyc();
            if (k == 1) begin
                #3 chk("sat_mid", {30'd0, s_count}, 32'd3);
            end
        end
        #3 chk("cnt_wide", {16'd0, stall_count}, 32'd6);
        chk("cnt_sat", {30'd0, s_count}, 32'd3);

        // reset asserted mid-stall drops the stall and clears the counter
        cyc();
        set_id(1'b1, 5'd5, 5'd2, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc();
        set_id(1'b1, 5'd6, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1 chk("pre_rst_stall", {31'd0, stall_if_id}, 32'd1);
        rst = 1'b0;
        #1 chk_ctl("rst_mid_stall", 7'b0_1_1_00_00);
        cyc();
        rst = 1'b1;
        #3 chk("rst_cnt_clear", {16'd0, stall_count}, 32'd0);
        chk_ctl("rst_sb_clear", 7'b0_0_0_00_00);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
